downscale_seq_ctrl: RTL and testbench

DOWNSCALE_SEQ_CTRL -- requirements
Module: downscale_seq_ctrl

---
 rtl/downscale_pkg.sv | 53 +++++
 rtl/downscale_phase_cnt.sv | 35 +++
 rtl/downscale_seq_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_downscale_seq_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/downscale_pkg.sv
// Shared definitions for the downscale sequencer: resolution table,
// FSM state encoding and default table depth. Width macros defaulted here.
`ifndef RESOLUTION_PAIR_LOG2
`define RESOLUTION_PAIR_LOG2 3
`endif
`ifndef MAX_ROW_LOG2
`define MAX_ROW_LOG2 12
`endif
`ifndef MAX_COL_LOG2
`define MAX_COL_LOG2 12
`endif

package downscale_pkg;

    localparam int NUM_PAIRS_DEF = 4;
    localparam int IDX_W = `RESOLUTION_PAIR_LOG2;
    localparam int ROW_W = `MAX_ROW_LOG2;
    localparam int COL_W = `MAX_COL_LOG2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [ROW_W-1:0] src_w;
        logic [COL_W-1:0] src_h;
        logic [ROW_W-1:0] tar_w;
        logic [COL_W-1:0] tar_h;
        logic [2:0]       x_f;
        logic [2:0]       y_f;
    } res_cfg_t;

    function automatic res_cfg_t res_lookup(input logic [IDX_W-1:0] idx);
        res_cfg_t c;
        c = '0;
        case (idx)
            IDX_W'(0): c = '{ROW_W'(1920), COL_W'(1080),
                             ROW_W'(960), COL_W'(540), 3'd2, 3'd2};
            IDX_W'(1): c = '{ROW_W'(1920), COL_W'(1080),
                             ROW_W'(640), COL_W'(360), 3'd3, 3'd3};
            IDX_W'(2): c = '{ROW_W'(3840), COL_W'(2160),
                             ROW_W'(960), COL_W'(540), 3'd4, 3'd4};
            IDX_W'(3): c = '{ROW_W'(1280), COL_W'(720),
                             ROW_W'(640), COL_W'(360), 3'd2, 3'd2};
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/downscale_phase_cnt.sv
// Wrap counter 0..limit with terminal flag; clr has priority over inc.
// Ports: clk, rst_n, clr, inc, limit in; cnt, last out.
module downscale_phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         last
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign last = (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = last ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/downscale_seq_ctrl.sv
// Downscaler sequencer: latches a resolution pair at vsync and emits per-beat
// FIR phases one cycle after each active beat. Optional DOWNSCALE_LINE_CHECK_EN.
// In: clk, rst_n, vsync, hsync, data_enable, resolution_pair_idx.
// Out: factors, target size, pix_valid, phases, emits, line_sel, frame_done,
// cfg_err, line_err.
module downscale_seq_ctrl
    import downscale_pkg::*;
#(
    parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             vsync,
    input  logic                             hsync,
    input  logic                             data_enable,
    input  logic [`RESOLUTION_PAIR_LOG2-1:0] resolution_pair_idx,
    output logic [2:0]                       X_factor,
    output logic [2:0]                       Y_factor,
    output logic [`MAX_ROW_LOG2-1:0]         tar_width,
    output logic [`MAX_COL_LOG2-1:0]         tar_height,
    output logic                             pix_valid,
    output logic [2:0]                       col_phase,
    output logic [2:0]                       row_phase,
    output logic                             x_emit,
    output logic                             y_emit,
    output logic                             line_sel,
    output logic                             frame_done,
    output logic                             cfg_err,
    output logic                             line_err
);

    state_e           state_q, state_d;
    logic [2:0]       x_f_q, x_f_d, y_f_q, y_f_d;
    logic [ROW_W-1:0] tar_w_q, tar_w_d;
    logic [COL_W-1:0] tar_h_q, tar_h_d;
    logic [COL_W-1:0] src_h_q, src_h_d;
    logic [COL_W-1:0] row_cnt_q, row_cnt_d;
    logic             cfg_err_q, cfg_err_d;
    logic             pix_valid_q, pix_valid_d;
    logic [2:0]       col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic             x_emit_q, x_emit_d, y_emit_q, y_emit_d;
    logic             line_sel_q, line_sel_d;
    logic             frame_done_q, frame_done_d;

    res_cfg_t         cfg;
    logic             idx_bad;
    logic             frame_full;
    logic             beat;
    logic             line_end;
    logic [2:0]       col_cnt, row_cnt;
    logic             col_last, row_last;
    logic             unused_hsync;

    assign unused_hsync = hsync;

    assign cfg     = res_lookup(resolution_pair_idx);
    assign idx_bad = 32'(resolution_pair_idx) >= NUM_PAIRS;

    // All source rows consumed; later lines must not produce beats.
    assign frame_full = (row_cnt_q == src_h_q);

    assign beat = data_enable && !vsync &&
                  ((state_q == LINE) ||
                   ((state_q == HBLANK) && !frame_full));

    assign line_end = !vsync && !data_enable && (state_q == LINE);

    downscale_phase_cnt #(.W(3)) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (vsync || line_end),
        .inc   (beat),
        .limit (x_f_q - 3'd1),
        .cnt   (col_cnt),
        .last  (col_last)
    );

    downscale_phase_cnt #(.W(3)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (vsync),
        .inc   (line_end),
        .limit (y_f_q - 3'd1),
        .cnt   (row_cnt),
        .last  (row_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            HBLANK: begin
                if (frame_full)       state_d = DONE;
                else if (data_enable) state_d = LINE;
            end
            LINE:    if (!data_enable) state_d = HBLANK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (vsync) state_d = idx_bad ? IDLE : HBLANK;
    end

    always_comb begin
        x_f_d        = x_f_q;
        y_f_d        = y_f_q;
        tar_w_d      = tar_w_q;
        tar_h_d      = tar_h_q;
        src_h_d      = src_h_q;
        cfg_err_d    = cfg_err_q;
        row_cnt_d    = row_cnt_q;
        line_sel_d   = line_sel_q;
        pix_valid_d  = beat;
        col_ph_d     = col_ph_q;
        row_ph_d     = row_ph_q;
        x_emit_d     = 1'b0;
        y_emit_d     = 1'b0;
        frame_done_d = (state_q != DONE) && (state_d == DONE);

        if (vsync) begin
            cfg_err_d  = idx_bad;
            x_f_d      = idx_bad ? 3'd0 : cfg.x_f;
            y_f_d      = idx_bad ? 3'd0 : cfg.y_f;
            tar_w_d    = idx_bad ? '0 : cfg.tar_w;
            tar_h_d    = idx_bad ? '0 : cfg.tar_h;
            src_h_d    = idx_bad ? '0 : cfg.src_h;
            row_cnt_d  = '0;
            line_sel_d = 1'b0;
            col_ph_d   = 3'd0;
            row_ph_d   = 3'd0;
        end else begin
            if (line_end) begin
                row_cnt_d = row_cnt_q + COL_W'(1);
                if (row_last) line_sel_d = ~line_sel_q;
            end
            if (beat) begin
                col_ph_d = col_cnt;
                row_ph_d = row_cnt;
                x_emit_d = col_last;
                y_emit_d = row_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_f_q        <= '0;
            y_f_q        <= '0;
            tar_w_q      <= '0;
            tar_h_q      <= '0;
            src_h_q      <= '0;
            row_cnt_q    <= '0;
            cfg_err_q    <= 1'b0;
            pix_valid_q  <= 1'b0;
            col_ph_q     <= '0;
            row_ph_q     <= '0;
            x_emit_q     <= 1'b0;
            y_emit_q     <= 1'b0;
            line_sel_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_f_q        <= x_f_d;
            y_f_q        <= y_f_d;
            tar_w_q      <= tar_w_d;
            tar_h_q      <= tar_h_d;
            src_h_q      <= src_h_d;
            row_cnt_q    <= row_cnt_d;
            cfg_err_q    <= cfg_err_d;
            pix_valid_q  <= pix_valid_d;
            col_ph_q     <= col_ph_d;
            row_ph_q     <= row_ph_d;
            x_emit_q     <= x_emit_d;
            y_emit_q     <= y_emit_d;
            line_sel_q   <= line_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef DOWNSCALE_LINE_CHECK_EN
    logic [ROW_W-1:0] src_w_q, src_w_d;
    logic [ROW_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             line_err_q, line_err_d;

    always_comb begin
        src_w_d    = src_w_q;
        beat_cnt_d = beat_cnt_q;
        line_err_d = line_err_q;
        if (vsync) begin
            src_w_d    = idx_bad ? '0 : cfg.src_w;
            beat_cnt_d = '0;
            line_err_d = 1'b0;
        end else if (line_end) begin
            beat_cnt_d = '0;
            if (beat_cnt_q != src_w_q) line_err_d = 1'b1;
        end else if (beat) begin
            beat_cnt_d = beat_cnt_q + ROW_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_w_q    <= '0;
            beat_cnt_q <= '0;
            line_err_q <= 1'b0;
        end else begin
            src_w_q    <= src_w_d;
            beat_cnt_q <= beat_cnt_d;
            line_err_q <= line_err_d;
        end
    end

    assign line_err = line_err_q;
`else
    logic [ROW_W-1:0] unused_src_w;
    assign unused_src_w = cfg.src_w;
    assign line_err     = 1'b0;
`endif

    assign X_factor   = x_f_q;
    assign Y_factor   = y_f_q;
    assign tar_width  = tar_w_q;
    assign tar_height = tar_h_q;
    assign pix_valid  = pix_valid_q;
    assign col_phase  = col_ph_q;
    assign row_phase  = row_ph_q;
    assign x_emit     = x_emit_q;
    assign y_emit     = y_emit_q;
    assign line_sel   = line_sel_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_downscale_seq_ctrl.sv
// Scoreboard bench for downscale_seq_ctrl: per-beat phases, frame/line
// bookkeeping, vsync priority, bad index, async reset, optional line check.
module tb_downscale_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic hsync = 1'b0;
    logic data_enable = 1'b0;
    logic [`RESOLUTION_PAIR_LOG2-1:0] resolution_pair_idx = '0;
    logic [2:0] X_factor, Y_factor, col_phase, row_phase;
    logic [`MAX_ROW_LOG2-1:0] tar_width;
    logic [`MAX_COL_LOG2-1:0] tar_height;
    logic pix_valid, x_emit, y_emit, line_sel;
    logic frame_done, cfg_err, line_err;

    always #5 clk = ~clk;

    downscale_seq_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .vsync               (vsync),
        .hsync               (hsync),
        .data_enable         (data_enable),
        .resolution_pair_idx (resolution_pair_idx),
        .X_factor            (X_factor),
        .Y_factor            (Y_factor),
        .tar_width           (tar_width),
        .tar_height          (tar_height),
        .pix_valid           (pix_valid),
        .col_phase           (col_phase),
        .row_phase           (row_phase),
        .x_emit              (x_emit),
        .y_emit              (y_emit),
        .line_sel            (line_sel),
        .frame_done          (frame_done),
        .cfg_err             (cfg_err),
        .line_err            (line_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    int tb_x [4] = '{2, 3, 4, 2};
    int tb_y [4] = '{2, 3, 4, 2};
    int tb_tw[4] = '{960, 640, 960, 640};
    int tb_th[4] = '{540, 360, 540, 360};
    int tb_sh[4] = '{1080, 1080, 2160, 720};

    int m_col, m_row, m_x, m_y;
    logic m_sel;
    logic [7:0] sb[$];

    int xe_cnt = 0;
    int ye_lines = 0;
    int fd_cnt = 0;
    logic prev_ye = 1'b0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (frame_done) fd_cnt++;
        if (pix_valid) begin
            if (x_emit) xe_cnt++;
            if (y_emit && !prev_ye) ye_lines++;
            prev_ye = y_emit;
            if (sb.size() == 0) begin
                chk("pix_unexp", 32'(pix_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("beat", {24'd0, col_phase, row_phase, x_emit, y_emit},
                    {24'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset(input int idx);
        m_col = 0;
        m_row = 0;
        m_sel = 1'b0;
        prev_ye = 1'b0;
        if (idx < 4) begin
            m_x = tb_x[idx];
            m_y = tb_y[idx];
        end else begin
            m_x = 0;
            m_y = 0;
        end
    endtask

    task automatic start_frame(input int idx);
        vsync = 1'b1;
        resolution_pair_idx = 3'(idx);
        tick();
        vsync = 1'b0;
        model_reset(idx);
    endtask

    task automatic push_beat();
        sb.push_back({3'(m_col), 3'(m_row), m_col == m_x - 1, m_row == m_y - 1});
        m_col = (m_col == m_x - 1) ? 0 : m_col + 1;
    endtask

    task automatic model_line_end();
        m_col = 0;
        if (m_row == m_y - 1) begin
            m_row = 0;
            m_sel = ~m_sel;
        end else begin
            m_row++;
        end
    endtask

    task automatic drive_line(input int n, input bit acc);
        for (int i = 0; i < n; i++) begin
            data_enable = 1'b1;
            if (acc) push_beat();
            tick();
        end
        data_enable = 1'b0;
        if (acc) model_line_end();
        tick();
        tick();
        if (acc) chk("line_sel", 32'(line_sel), 32'(m_sel));
    endtask

    initial begin
        int x0, fd0;
        logic exp_lerr;

        tick();
        tick();
        chk("rst_xf", 32'(X_factor), 0);
        chk("rst_tw", 32'(tar_width), 0);
        chk("rst_pv", 32'(pix_valid), 0);
        chk("rst_cfg", 32'(cfg_err), 0);
        chk("rst_lerr", 32'(line_err), 0);
        chk("rst_fd", 32'(frame_done), 0);
        rst_n = 1'b1;
        tick();

        // idx 1: two full lines, remaining lines short
        start_frame(1);
        chk("i1_xf", 32'(X_factor), 3);
        chk("i1_yf", 32'(Y_factor), 3);
        chk("i1_tw", 32'(tar_width), 640);
        chk("i1_th", 32'(tar_height), 360);
        ye_lines = 0;
        fd0 = fd_cnt;
        x0 = xe_cnt;
        drive_line(1920, 1);
        chk("i1_xemit", 32'(xe_cnt - x0), 640);
        drive_line(1920, 1);
        for (int i = 2; i < tb_sh[1]; i++) drive_line(3, 1);
        chk("i1_fd_time", 32'(frame_done), 1);
        tick();
        chk("i1_fd_cnt", 32'(fd_cnt - fd0), 1);
        chk("i1_ylines", 32'(ye_lines), 360);

        // idx 0: vsync with data_enable drops that beat
        vsync = 1'b1;
        resolution_pair_idx = 3'd0;
        data_enable = 1'b1;
        tick();
        vsync = 1'b0;
        data_enable = 1'b0;
        model_reset(0);
        chk("vs_drop", 32'(pix_valid), 0);
        tick();
        drive_line(4, 1);

        // bad index
        start_frame(5);
        chk("bad_cfg", 32'(cfg_err), 1);
        chk("bad_xf", 32'(X_factor), 0);
        chk("bad_tw", 32'(tar_width), 0);
        data_enable = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bad_pv", 32'(pix_valid), 0);
        data_enable = 1'b0;
        tick();

        // idx 0: reset at row 300
        start_frame(0);
        chk("i0_xf", 32'(X_factor), 2);
        for (int i = 0; i < 300; i++) drive_line(2, 1);
        for (int i = 0; i < 5; i++) begin
            data_enable = 1'b1;
            push_beat();
            tick();
        end
        data_enable = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        fd0 = fd_cnt;
        chk("mr_pv", 32'(pix_valid), 0);
        chk("mr_xf", 32'(X_factor), 0);
        chk("mr_tw", 32'(tar_width), 0);
        chk("mr_th", 32'(tar_height), 0);
        chk("mr_col", 32'(col_phase), 0);
        chk("mr_sel", 32'(line_sel), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        drive_line(3, 0);
        chk("mr_no_fd", 32'(fd_cnt - fd0), 0);
        start_frame(0);
        chk("mr_th2", 32'(tar_height), 540);
        for (int i = 0; i < tb_sh[0]; i++) drive_line(2, 1);
        chk("i0_fd_time", 32'(frame_done), 1);
        tick();
        chk("i0_fd_cnt", 32'(fd_cnt - fd0), 1);

        // idx 3: short line 10
        start_frame(3);
        for (int i = 0; i < 10; i++) drive_line(1280, 1);
        chk("lerr_ok", 32'(line_err), 0);
        drive_line(1279, 1);
`ifdef DOWNSCALE_LINE_CHECK_EN
        exp_lerr = 1'b1;
`else
        exp_lerr = 1'b0;
`endif
        chk("lerr_set", 32'(line_err), 32'(exp_lerr));
        drive_line(1280, 1);
        chk("lerr_hold", 32'(line_err), 32'(exp_lerr));

        // idx 2: extra line after the last source row
        start_frame(2);
        chk("lerr_clr", 32'(line_err), 0);
        chk("i2_xf", 32'(X_factor), 4);
        fd0 = fd_cnt;
        for (int i = 0; i < tb_sh[2]; i++) drive_line(4, 1);
        chk("i2_fd_time", 32'(frame_done), 1);
        tick();
        chk("i2_fd_cnt", 32'(fd_cnt - fd0), 1);
        drive_line(4, 0);
        tick();
        chk("i2_fd_once", 32'(fd_cnt - fd0), 1);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
